// File: rtl/aes_128_inv_key_sched.sv
// Reverse AES-128 key schedule: loads the round-10 key and steps back to round 0, one key per handshake.
// Optional final-key self check is enabled by defining AES_INV_KEY_CHECK_EN.
module aes_128_inv_key_sched (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [127:0] last_key,
    input  logic         load,
    output logic [127:0] key_out,
    output logic [3:0]   key_round,
    output logic         key_valid,
    input  logic         key_ready,
    output logic         busy,
    output logic         done,
    output logic [31:0]  sbox,
    input  logic [31:0]  new_sbox
`ifdef AES_INV_KEY_CHECK_EN
    ,
    input  logic [127:0] ref_key,
    output logic         key_mismatch
`endif
);

    typedef enum logic {S_IDLE, S_EMIT} state_t;

    state_t       r_state;
    logic [127:0] r_key;
    logic [3:0]   r_round;
    logic [7:0]   r_rcon;
    logic         r_valid;
    logic         r_busy;
    logic         r_done;

    logic         w_hs;
    logic         w_last;
    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [31:0]  w_t;
    logic [127:0] w_prev_key;
    logic [7:0]   w_rcon_prev;

    assign {w_w0, w_w1, w_w2, w_w3} = r_key;
    assign w_hs   = (r_state == S_EMIT) && r_valid && key_ready;
    assign w_last = (r_round == 4'd0);

    // w2^w3 is the previous round's w3; SubWord and RotWord commute, so rotate after the S-box
    assign sbox        = w_w2 ^ w_w3;
    assign w_t         = {new_sbox[23:0], new_sbox[31:24]} ^ {r_rcon, 24'h0};
    assign w_prev_key  = {w_w0 ^ w_t, w_w1 ^ w_w0, w_w2 ^ w_w1, w_w3 ^ w_w2};
    assign w_rcon_prev = r_rcon[0] ? (((r_rcon ^ 8'h1b) >> 1) | 8'h80) : (r_rcon >> 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_key   <= '0;
            r_round <= '0;
            r_rcon  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (load) begin
                r_state <= S_EMIT;
                r_key   <= last_key;
                r_round <= 4'd10;
                r_rcon  <= 8'h36;
                r_valid <= 1'b1;
                r_busy  <= 1'b1;
            end else if (w_hs) begin
                if (w_last) begin
                    // round-0 key stays on key_out after the sequence ends
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end else begin
                    r_key   <= w_prev_key;
                    r_round <= r_round - 4'd1;
                    r_rcon  <= w_rcon_prev;
                end
            end
        end
    end

    assign key_out   = r_key;
    assign key_round = r_round;
    assign key_valid = r_valid;
    assign busy      = r_busy;
    assign done      = r_done;

`ifdef AES_INV_KEY_CHECK_EN
    logic [127:0] r_ref;
    logic         r_mismatch;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ref      <= '0;
            r_mismatch <= 1'b0;
        end else if (load) begin
            r_ref      <= ref_key;
            r_mismatch <= 1'b0;
        end else if (w_hs && w_last) begin
            r_mismatch <= (r_key != r_ref);
        end
    end

    assign key_mismatch = r_mismatch;
`endif

endmodule

// File: tb/tb_aes_128_inv_key_sched.sv
// Directed bench for the reverse AES-128 key schedule; supplies the S-box and a forward-expansion model.
module tb_aes_128_inv_key_sched;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    localparam logic [79:0] RCON = 80'h01020408102040801b36;

    // FIPS-197 appendix A.1 round keys, index = round
    localparam logic [127:0] FK [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [127:0] last_key = '0;
    logic         load = 1'b0;
    logic [127:0] key_out;
    logic [3:0]   key_round;
    logic         key_valid;
    logic         key_ready = 1'b0;
    logic         busy;
    logic         done;
    logic [31:0]  sbox;
    logic [31:0]  new_sbox;
`ifdef AES_INV_KEY_CHECK_EN
    logic [127:0] ref_key = '0;
    logic         key_mismatch;
`endif

    int checks = 0;
    int failures = 0;
    logic [127:0] mk [0:10];

    always #5 clk = ~clk;

    function automatic logic [7:0] sb(input logic [7:0] x);
        int i;
        i = int'(x);
        return SBOX[2047 - 8*i -: 8];
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
    endfunction

    assign new_sbox = subw(sbox);

    aes_128_inv_key_sched dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .last_key  (last_key),
        .load      (load),
        .key_out   (key_out),
        .key_round (key_round),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .busy      (busy),
        .done      (done),
        .sbox      (sbox),
        .new_sbox  (new_sbox)
`ifdef AES_INV_KEY_CHECK_EN
        ,
        .ref_key      (ref_key),
        .key_mismatch (key_mismatch)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // forward expansion of a cipher key into mk[0..10]
    task automatic expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        {w[0], w[1], w[2], w[3]} = k;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0)
                t = subw({t[23:0], t[31:24]}) ^ {RCON[79 - 8*(i/4 - 1) -: 8], 24'h0};
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            mk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic do_load(input logic [127:0] k);
        load     = 1'b1;
        last_key = k;
        tick();
        load     = 1'b0;
    endtask

    // full-throughput walk of mk[10..0] starting from a freshly loaded key
    task automatic run_mk(input string tag);
        key_ready = 1'b1;
        for (int r = 10; r >= 0; r--) begin
            chk({tag, "_key"}, key_out, mk[r]);
            chk({tag, "_round"}, {124'h0, key_round}, 128'(r));
            tick();
        end
        chk({tag, "_done"}, {127'h0, done}, 128'h1);
        chk({tag, "_valid_end"}, {127'h0, key_valid}, 128'h0);
    endtask

    initial begin
        int e;
        int hs;
        logic [127:0] k;

        // reset state
        #2;
        chk("rst_key", key_out, 128'h0);
        chk("rst_round", {124'h0, key_round}, 128'h0);
        chk("rst_flags", {124'h0, key_valid, busy, done, 1'b0}, 128'h0);
        chk("rst_sbox", {96'h0, sbox}, 128'h0);
        tick();
        reset_n = 1'b1;
        tick();

        // 1: FIPS-197 vector, key_ready held high
        key_ready = 1'b1;
        do_load(FK[10]);
        chk("t1_valid", {126'h0, key_valid, busy}, 128'h3);
        chk("t1_sbox10", {96'h0, sbox}, 128'h575c006e);
        hs = 0;
        for (int r = 10; r >= 0; r--) begin
            chk("t1_key", key_out, FK[r]);
            chk("t1_round", {124'h0, key_round}, 128'(r));
            chk("t1_nodone", {127'h0, done}, 128'h0);
            if (key_valid && key_ready) hs++;
            tick();
        end
        chk("t1_hs", 128'(hs), 128'd11);
        chk("t1_done", {127'h0, done}, 128'h1);
        chk("t1_idle", {126'h0, key_valid, busy}, 128'h0);
        tick();
        chk("t1_done_pulse", {127'h0, done}, 128'h0);
        repeat (3) tick();
        chk("t1_hold_key", key_out, FK[0]);
        chk("t1_hold_round", {123'h0, key_valid, key_round}, 128'h0);

        // 2: random stalls, same sequence
        key_ready = 1'b0;
        do_load(FK[10]);
        e = 10;
        for (int c = 0; c < 300 && e >= 0; c++) begin
            chk("t2_key", key_out, FK[e]);
            chk("t2_round", {124'h0, key_round}, 128'(e));
            key_ready = 1'($urandom_range(1));
            if (key_ready) e--;
            tick();
        end
        chk("t2_finished", 128'(e), 128'hffffffff_ffffffff_ffffffff_ffffffff);
        chk("t2_done", {127'h0, done}, 128'h1);

        // 3: reload mid-sequence at round 5, with simultaneous handshake
        k = 128'h000102030405060708090a0b0c0d0e0f;
        expand(k);
        key_ready = 1'b1;
        do_load(FK[10]);
        repeat (5) tick();
        chk("t3_at5", {124'h0, key_round}, 128'd5);
        chk("t3_key5", key_out, FK[5]);
        do_load(mk[10]);
        chk("t3_round10", {124'h0, key_round}, 128'd10);
        chk("t3_newkey", key_out, mk[10]);
        chk("t3_nodone", {127'h0, done}, 128'h0);
        tick();
        chk("t3_rcon36", key_out, mk[9]);
        chk("t3_round9", {124'h0, key_round}, 128'd9);
        repeat (10) tick();
        chk("t3_final", key_out, mk[0]);
        chk("t3_done", {127'h0, done}, 128'h1);

        // 4: async reset mid-sequence, then no progress until load
        do_load(FK[10]);
        repeat (3) tick();
        reset_n = 1'b0;
        #1;
        chk("t4_key", key_out, 128'h0);
        chk("t4_flags", {120'h0, key_round, key_valid, busy, done, 1'b0}, 128'h0);
        chk("t4_sbox", {96'h0, sbox}, 128'h0);
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        chk("t4_stay_idle", {123'h0, key_valid, key_round}, 128'h0);
        chk("t4_stay_key", key_out, 128'h0);
        expand(FK[0]);
        do_load(FK[10]);
        run_mk("t4_resume");

        // 5: random cipher keys against the forward model
        for (int n = 0; n < 100; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            expand(k);
            do_load(mk[10]);
            run_mk("t5");
        end

`ifdef AES_INV_KEY_CHECK_EN
        // 6: final-key self check
        expand(FK[0]);
        ref_key = FK[0];
        do_load(mk[10]);
        chk("t6_clear", {127'h0, key_mismatch}, 128'h0);
        run_mk("t6_good");
        chk("t6_match", {127'h0, key_mismatch}, 128'h0);
        ref_key = FK[0] ^ 128'h1;
        do_load(mk[10]);
        run_mk("t6_bad");
        chk("t6_mismatch", {127'h0, key_mismatch}, 128'h1);
        do_load(mk[10]);
        chk("t6_reload_clear", {127'h0, key_mismatch}, 128'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
